// File: rtl/asicfreq_pkg.sv
// asicfreq_pkg: definitions shared by the asicfreq stimulus generator and
// the asicfreq frequency counter.
//   - register address map for the strobe/addr/value write bus
//   - CTRL register bit positions
//   - generator FSM state encoding
//   - default accumulator/register width
package asicfreq_pkg;

    localparam int ACC_W_DEF = 32;

    localparam logic [1:0] ADDR_CTRL  = 2'd0;
    localparam logic [1:0] ADDR_INC   = 2'd1;
    localparam logic [1:0] ADDR_BURST = 2'd2;
    // Address 3 is reserved; writes to it are dropped.

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_BURST_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/asicfreq_gen_if.sv
// asicfreq_gen_if: register-write bus plus generator status outputs.
//   strobe  : one-cycle write request (master -> slave)
//   addr    : register select (master -> slave)
//   value   : write data (master -> slave)
//   sig_o   : generated square wave (slave -> master)
//   sig_oeb : pad output enable, active low (slave -> master)
//   busy    : generator active (slave -> master)
//   done    : one-cycle completion pulse (slave -> master)
//   oc      : rising-edge count since last start (slave -> master)
//   state   : FSM state, for debug visibility (slave -> master)
// Write semantics: there is no back-pressure. A write is accepted at every
// rising clk edge where strobe is 1; the master holds addr/value stable
// around that edge and deasserts strobe after one cycle.
interface asicfreq_gen_if #(
    parameter int ACC_W = asicfreq_pkg::ACC_W_DEF
);
    logic                  strobe;
    logic [1:0]            addr;
    logic [ACC_W-1:0]      value;
    logic                  sig_o;
    logic                  sig_oeb;
    logic                  busy;
    logic                  done;
    logic [ACC_W-1:0]      oc;
    asicfreq_pkg::state_t  state;

    modport master (
        output strobe, addr, value,
        input  sig_o, sig_oeb, busy, done, oc, state
    );

    modport slave (
        input  strobe, addr, value,
        output sig_o, sig_oeb, busy, done, oc, state
    );
endinterface

// File: rtl/asicfreq_nco.sv
// asicfreq_nco: phase accumulator.
//   clk, resetb : clock, asynchronous active-low reset
//   en          : add inc to the accumulator this cycle
//   clr         : force the accumulator to zero (wins over en)
//   inc         : phase step
//   msb         : accumulator MSB, taken straight from the register
//   rise        : high in the cycle whose edge will take msb from 0 to 1
module asicfreq_nco #(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             en,
    input  logic             clr,
    input  logic [ACC_W-1:0] inc,
    output logic             msb,
    output logic             rise
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_sum;

    assign w_sum = r_acc + inc;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= w_sum;
        end
    end

    assign msb  = r_acc[ACC_W-1];
    // Look-ahead so the edge counter can step on the same edge as the rise.
    assign rise = en && !clr && !r_acc[ACC_W-1] && w_sum[ACC_W-1];

endmodule

// File: rtl/asicfreq_gen.sv
// asicfreq_gen: programmable square-wave generator built on a phase
// accumulator, running continuously or for a burst of N rising edges.
//   clk    : system clock, rising edge
//   resetb : asynchronous active-low reset
//   bus    : register write bus and status outputs (asicfreq_gen_if.slave)
// Registers: CTRL (bit0 enable, bit1 burst mode), INC (phase step),
// BURST (edge target). CTRL acts as a command register: its effect is
// carried entirely by the FSM state, so it is not stored.
module asicfreq_gen
    import asicfreq_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic          clk,
    input  logic          resetb,
    asicfreq_gen_if.slave bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_inc;
    logic [ACC_W-1:0] r_burst;
    logic [ACC_W-1:0] r_oc;
    logic             r_done;

    logic             w_wr_ctrl;
    logic             w_start;
    logic             w_stop;
    logic             w_en;
    logic             w_clr;
    logic             w_msb;
    logic             w_rise;
    logic             w_oc_clr;
    logic             w_done_nxt;
    logic [ACC_W:0]   w_oc_inc;
    logic             w_burst_hit;

    assign w_wr_ctrl = bus.strobe && (bus.addr == ADDR_CTRL);
    assign w_start   = w_wr_ctrl &&  bus.value[CTRL_EN_BIT];
    assign w_stop    = w_wr_ctrl && !bus.value[CTRL_EN_BIT];

    // Accumulate while generating; in DRAIN keep going only until the
    // high phase has finished, then park the accumulator at zero.
    assign w_en  = (r_state == ST_RUN) || (r_state == ST_BURST) ||
                   ((r_state == ST_DRAIN) && w_msb);
    assign w_clr = (r_state == ST_IDLE) || ((r_state == ST_DRAIN) && !w_msb);

    // Widened compare so a target that is already at or below the count
    // stops the burst at the next rise, without wrap-around surprises.
    assign w_oc_inc    = {1'b0, r_oc} + {{ACC_W{1'b0}}, 1'b1};
    assign w_burst_hit = (w_oc_inc >= {1'b0, r_burst});

    asicfreq_nco #(.ACC_W(ACC_W)) u_nco (
        .clk    (clk),
        .resetb (resetb),
        .en     (w_en),
        .clr    (w_clr),
        .inc    (r_inc),
        .msb    (w_msb),
        .rise   (w_rise)
    );

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_oc_clr    = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_oc_clr = 1'b1;
                    if (!bus.value[CTRL_BURST_BIT]) begin
                        w_state_nxt = ST_RUN;
                    end else if (r_burst == '0) begin
                        // Empty burst: report completion without leaving IDLE.
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_BURST;
                    end
                end
            end
            ST_RUN: begin
                if (w_stop) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_BURST: begin
                if (w_stop || (w_rise && w_burst_hit)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!w_msb) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_inc   <= '0;
            r_burst <= '0;
        end else if (bus.strobe) begin
            if (bus.addr == ADDR_INC) begin
                r_inc <= bus.value;
            end
            if (bus.addr == ADDR_BURST) begin
                r_burst <= bus.value;
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_oc <= '0;
        end else if (w_oc_clr) begin
            r_oc <= '0;
        end else if (w_rise) begin
            r_oc <= w_oc_inc[ACC_W-1:0];
        end
    end

    assign bus.sig_o   = w_msb;
    assign bus.sig_oeb = (r_state == ST_IDLE);
    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.done    = r_done;
    assign bus.oc      = r_oc;
    assign bus.state   = r_state;

endmodule

// File: tb/tb_asicfreq_gen.sv
// Testbench for asicfreq_gen: directed scenarios plus randomized register
// traffic, checked every cycle against a phase-arithmetic reference model.
module tb_asicfreq_gen;

    localparam int W = 32;
    localparam logic [31:0] HALF = 32'h8000_0000;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    logic check_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    asicfreq_gen_if #(.ACC_W(W)) bus ();

    asicfreq_gen #(.ACC_W(W)) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 continuous, 2 burst, 3 finishing the last high phase
    typedef struct {
        logic [31:0] phase;
        logic [31:0] oc;
        logic [31:0] inc;
        logic [31:0] target;
        int          mode;
        logic        done;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.phase = 0; r.oc = 0; r.inc = 0; r.target = 0; r.mode = 0; r.done = 0;
        return r;
    endfunction

    function automatic mdl_t step(mdl_t cur, logic s, logic [1:0] a, logic [31:0] v);
        mdl_t n;
        longint nxt;
        logic rise;
        logic en_wr;
        logic dis_wr;
        n = cur;
        n.done = 0;
        en_wr  = s && (a == 2'd0) && v[0];
        dis_wr = s && (a == 2'd0) && !v[0];
        if (s && a == 2'd1) n.inc = v;
        if (s && a == 2'd2) n.target = v;
        if (cur.mode == 0) begin
            n.phase = 0;
            if (en_wr) begin
                n.oc = 0;
                if (!v[1]) n.mode = 1;
                else if (cur.target == 0) n.done = 1;
                else n.mode = 2;
            end
        end else if (cur.mode == 3) begin
            if (cur.phase < HALF) begin
                n.phase = 0;
                n.mode = 0;
                n.done = 1;
            end else begin
                n.phase = 32'((longint'(cur.phase) + longint'(cur.inc)) % 64'h1_0000_0000);
            end
        end else begin
            nxt = (longint'(cur.phase) + longint'(cur.inc)) % 64'h1_0000_0000;
            rise = (cur.phase < HALF) && (nxt >= longint'(HALF));
            n.phase = 32'(nxt);
            if (rise) n.oc = cur.oc + 1;
            if (dis_wr) n.mode = 3;
            if (cur.mode == 2 && rise && (longint'(cur.oc) + 1 >= longint'(cur.target))) n.mode = 3;
        end
        return n;
    endfunction

    always @(posedge clk or negedge resetb) begin
        if (!resetb) m <= mdl_reset();
        else         m <= step(m, bus.strobe, bus.addr, bus.value);
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en && resetb) begin
            chk("cyc_sig_o",   {63'd0, bus.sig_o},   {63'd0, m.phase[31]});
            chk("cyc_sig_oeb", {63'd0, bus.sig_oeb}, {63'd0, (m.mode == 0)});
            chk("cyc_busy",    {63'd0, bus.busy},    {63'd0, (m.mode != 0)});
            chk("cyc_done",    {63'd0, bus.done},    {63'd0, m.done});
            chk("cyc_oc",      {32'd0, bus.oc},      {32'd0, m.oc});
        end
    end

    // ---------------- monitors ----------------
    logic [31:0] exp_q[$];
    logic [31:0] act_q[$];
    logic prev_sig = 1'b0;
    int   done_cnt = 0;
    int   hi_run = 0;
    int   last_hi = 0;

    always @(negedge clk) begin
        if (bus.sig_o && !prev_sig) act_q.push_back(32'(cyc));
        if (bus.sig_o) hi_run++;
        else if (hi_run > 0) begin
            last_hi = hi_run;
            hi_run = 0;
        end
        prev_sig = bus.sig_o;
        if (bus.done) done_cnt++;
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after an edge; the write is taken at the next edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] v);
        bus.strobe = 1'b1;
        bus.addr   = a;
        bus.value  = v;
        @(posedge clk);
        #1;
        bus.strobe = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i;
        i = 0;
        while (bus.busy && i < budget) begin
            tick();
            i++;
        end
        chk(name, {63'd0, bus.busy}, 64'd0);
    endtask

    task automatic wait_high(input string name, input int budget);
        int i;
        i = 0;
        while (!bus.sig_o && i < budget) begin
            tick();
            i++;
        end
        chk(name, {63'd0, bus.sig_o}, 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int d0;
        int r0;
        logic busy_seen;
        logic [31:0] inc;
        logic bm;
        bus.strobe = 1'b0;
        bus.addr   = 2'd0;
        bus.value  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sig_o",   {63'd0, bus.sig_o},   64'd0);
        chk("rst_sig_oeb", {63'd0, bus.sig_oeb}, 64'd1);
        chk("rst_busy",    {63'd0, bus.busy},    64'd0);
        chk("rst_done",    {63'd0, bus.done},    64'd0);
        chk("rst_oc",      {32'd0, bus.oc},      64'd0);
        @(negedge clk);
        resetb = 1'b1;
        check_en = 1'b1;
        tick();

        // Half-rate continuous run.
        wr(2'd1, 32'h8000_0000);
        wr(2'd0, 32'h1);
        chk("t1_busy_k",  {63'd0, bus.busy},    64'd1);
        chk("t1_oeb_k",   {63'd0, bus.sig_oeb}, 64'd0);
        chk("t1_sig_k",   {63'd0, bus.sig_o},   64'd0);
        tick();
        chk("t1_sig_k1",  {63'd0, bus.sig_o},   64'd1);
        chk("t1_oc_k1",   {32'd0, bus.oc},      64'd1);
        repeat (99) tick();
        chk("t1_oc_100",  {63'd0, (bus.oc >= 49 && bus.oc <= 51)}, 64'd1);
        chk("t1_oeb_100", {63'd0, bus.sig_oeb}, 64'd0);
        wr(2'd0, 32'h0);
        wait_idle("t1_stop", 20);
        tick();

        // Burst of three edges at quarter rate.
        wr(2'd2, 32'd3);
        wr(2'd1, 32'h4000_0000);
        act_q.delete();
        exp_q.delete();
        d0 = done_cnt;
        wr(2'd0, 32'h3);
        k = cyc;
        exp_q.push_back(32'(k + 2));
        exp_q.push_back(32'(k + 6));
        exp_q.push_back(32'(k + 10));
        wait_idle("t2_idle", 40);
        tick();
        chk("t2_edges", act_q.size(), 64'd3);
        while (exp_q.size() > 0 && act_q.size() > 0)
            chk("t2_edge_time", {32'd0, act_q.pop_front()}, {32'd0, exp_q.pop_front()});
        chk("t2_done_cnt", done_cnt - d0, 64'd1);
        chk("t2_oc",       {32'd0, bus.oc},      64'd3);
        chk("t2_busy",     {63'd0, bus.busy},    64'd0);
        chk("t2_oeb",      {63'd0, bus.sig_oeb}, 64'd1);

        // Empty burst.
        wr(2'd2, 32'd0);
        act_q.delete();
        d0 = done_cnt;
        wr(2'd0, 32'h3);
        chk("t3_done",  {63'd0, bus.done}, 64'd1);
        chk("t3_busy",  {63'd0, bus.busy}, 64'd0);
        chk("t3_oc",    {32'd0, bus.oc},   64'd0);
        busy_seen = 1'b0;
        repeat (6) begin
            tick();
            busy_seen = busy_seen | bus.busy;
        end
        chk("t3_busy_never", {63'd0, busy_seen}, 64'd0);
        chk("t3_no_edges",   act_q.size(), 64'd0);
        chk("t3_done_cnt",   done_cnt - d0, 64'd1);

        // Stop during a high phase: the high phase is never cut short.
        wr(2'd1, 32'h2000_0000);
        wr(2'd0, 32'h1);
        wait_high("t4_high", 10);
        d0 = done_cnt;
        wr(2'd0, 32'h0);
        wait_idle("t4_idle", 20);
        tick();
        chk("t4_high_len", last_hi, 64'd4);
        chk("t4_done_cnt", done_cnt - d0, 64'd1);

        // Reserved address: neither starts nor changes INC.
        wr(2'd3, 32'h3);
        tick();
        chk("t5_addr3_busy", {63'd0, bus.busy}, 64'd0);
        wr(2'd3, 32'h8000_0000);
        act_q.delete();
        wr(2'd0, 32'h1);
        k = cyc;
        repeat (5) tick();
        chk("t5_edges", act_q.size(), 64'd1);
        if (act_q.size() > 0) chk("t5_first_rise", {32'd0, act_q[0]}, 64'(k + 4));
        wr(2'd0, 32'h0);
        wait_idle("t5_idle", 20);
        tick();

        // f_clk/16 edge count against the output counter.
        wr(2'd1, 32'h1000_0000);
        act_q.delete();
        wr(2'd0, 32'h1);
        repeat (160) tick();
        chk("t6_oc_vs_edges", {32'd0, bus.oc}, 64'(act_q.size()));
        chk("t6_oc",          {32'd0, bus.oc}, 64'd10);
        wr(2'd0, 32'h0);
        wait_idle("t6_idle", 40);
        tick();

        // Asynchronous reset in the middle of a burst.
        wr(2'd2, 32'd10);
        wr(2'd1, 32'h4000_0000);
        wr(2'd0, 32'h3);
        wait_high("t7_high", 10);
        #2;
        resetb = 1'b0;
        #1;
        chk("t7_sig_o", {63'd0, bus.sig_o},   64'd0);
        chk("t7_oeb",   {63'd0, bus.sig_oeb}, 64'd1);
        chk("t7_oc",    {32'd0, bus.oc},      64'd0);
        chk("t7_busy",  {63'd0, bus.busy},    64'd0);
        @(negedge clk);
        resetb = 1'b1;
        tick();
        wr(2'd1, 32'h8000_0000);
        wr(2'd0, 32'h1);
        chk("t7_restart_busy", {63'd0, bus.busy}, 64'd1);
        tick();
        chk("t7_restart_sig", {63'd0, bus.sig_o}, 64'd1);
        chk("t7_restart_oc",  {32'd0, bus.oc},    64'd1);
        wr(2'd0, 32'h0);
        wait_idle("t7_idle", 20);
        tick();

        // Randomized register traffic; the per-cycle model check covers it.
        for (int it = 0; it < 15; it++) begin
            inc = $urandom_range(32'hC000_0000, 32'h0100_0000);
            wr(2'd1, inc);
            bm = 1'($urandom_range(1, 0));
            if (bm) wr(2'd2, $urandom_range(6, 0));
            wr(2'd0, {30'd0, bm, 1'b1});
            repeat ($urandom_range(40, 5)) begin
                case ($urandom_range(9, 0))
                    0: wr(2'd1, $urandom_range(32'hC000_0000, 32'h0100_0000));
                    1: wr(2'd2, $urandom_range(6, 0));
                    2: wr(2'd3, $urandom);
                    3: wr(2'd0, {30'd0, 1'($urandom_range(1, 0)), 1'b1});
                    default: tick();
                endcase
            end
            if (bus.busy) wr(2'd0, 32'h0);
            wait_idle("rnd_idle", 300);
            tick();
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
